uart_tx_arbiter: RTL



---
 rtl/uart_arb_pkg.sv | 38 +++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types, constants and the round-robin search helper for the UART Tx arbiter.
package uart_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READY
    } arb_state_e;

    // Encoding of the transmitter READY_BUSY line.
    localparam logic TX_READY = 1'b1;
    localparam logic TX_BUSY  = 1'b0;

    // Widest requester vector the helper handles.
    localparam int unsigned MAX_REQ = 8;

    // Index of the first set bit of req[num-1:0], searching upward from start and wrapping
    // modulo num. Returns start when no bit is set; callers qualify with |req.
    function automatic logic [2:0] first_set_from(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         start,
                                                  input int unsigned        num);
        logic [2:0]  pick;
        logic        found;
        int unsigned pos;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = (32'(start) + k) % num;
            if (!found && (k < num) && req[pos[2:0]]) begin
                pick  = pos[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         ptr_ext;
    logic [2:0]         pick;

    // Widen to the helper's fixed width, search, and narrow the result back.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        ptr_ext                = 3'(rr_ptr);
        pick                   = first_set_from(req_ext, ptr_ext, NUM_REQ);
        winner                 = ID_W'(pick);
        valid                  = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Latches the winner's word, requests one frame, and tracks it until the transmitter
// returns to ready. A request the transmitter never acknowledges ends in a tx_err pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             tx_done,
    output logic                           tx_err,
    output logic [$clog2(NUM_REQ)-1:0]     active_id,
    output logic                           UART_Tx_RQST,
    output logic [WORD_LENGTH-1:0]         Tx_DATA,
    input  logic                           UART_Tx_READY_BUSY
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   err_q, err_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   rqst_q, rqst_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;

    logic [ID_W-1:0]        pick_winner;
    logic                   pick_valid;
    logic                   tx_ready;
    logic                   start;
    logic                   timeout_hit;
    logic [ID_W-1:0]        ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Shared decode terms used by both the next-state and output logic.
    always_comb begin
        tx_ready    = (UART_Tx_READY_BUSY == TX_READY);
        start       = (state_q == IDLE) && pick_valid && tx_ready;
        timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        ptr_next    = (pick_winner == ID_W'(NUM_REQ - 1)) ? '0 : pick_winner + ID_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a busy indication beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (UART_Tx_READY_BUSY == TX_BUSY) begin
                    state_d = WAIT_READY;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_READY: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; pulses default to zero.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        id_d     = id_q;
        rqst_d   = rqst_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    gnt_d    = NUM_REQ'(1) << pick_winner;
                    data_d   = req_data[32'(pick_winner)*WORD_LENGTH +: WORD_LENGTH];
                    id_d     = pick_winner;
                    rqst_d   = 1'b1;
                    rr_ptr_d = ptr_next;
                    cnt_d    = '0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (UART_Tx_READY_BUSY == TX_BUSY) begin
                    rqst_d = 1'b0;
                end else if (timeout_hit) begin
                    rqst_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            WAIT_READY: begin
                if (tx_ready) begin
                    done_d = NUM_REQ'(1) << id_q;
                end
            end
            default: begin
                rqst_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            id_q     <= '0;
            rqst_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            id_q     <= id_d;
            rqst_q   <= rqst_d;
            data_q   <= data_d;
        end
    end

    assign gnt          = gnt_q;
    assign tx_done      = done_q;
    assign tx_err       = err_q;
    assign active_id    = id_q;
    assign UART_Tx_RQST = rqst_q;
    assign Tx_DATA      = data_q;

    // Pulse vectors are never more than one-hot.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_done_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));

    // The held word cannot move while a request is outstanding.
    a_data_stable : assert property (@(posedge clk) disable iff (rst)
        (state_q == ISSUE && $past(state_q) == ISSUE) |-> $stable(data_q));

endmodule
